rr_arb4_dec: RTL

- Round-robin arbiter and sequencer that shares one 2-to-4 decoder-driven resource between four requesters.
- Selects one requester and drives the decoder inputs (A0, A1, EN) plus a matching registered one-hot grant.
- Inserts a one-cycle break-before-make gap between successive grants so no two decoder outputs are ever active together.
- Sits directly upstream of a dec2x4-class decoder in the standard-cell datapath.

---
 rtl/rr_arb4_pkg.sv | 18 +
 rtl/rr_pick4.sv | 25 ++
 rtl/rr_arb4_dec.sv | 101 ++++++++++
 3 files changed

// File: rtl/rr_arb4_pkg.sv
// Shared types and constants for the four-way round-robin decoder arbiter.
package rr_arb4_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_GRANT = 2'b01,
    ST_GAP   = 2'b10
  } state_t;

  localparam int NREQ   = 4;
  localparam int CODE_W = 2;

  // One-hot image of a decoder select code, i.e. what a dec2x4 would drive.
  function automatic logic [NREQ-1:0] dec_code(input logic [CODE_W-1:0] code);
    dec_code = 4'b0001 << code;
  endfunction

endpackage

// File: rtl/rr_pick4.sv
// Combinational round-robin search: first requester at or after ptr_i, mod 4.
module rr_pick4
  import rr_arb4_pkg::*;
(
  input  logic [NREQ-1:0]   req_i,
  input  logic [CODE_W-1:0] ptr_i,
  output logic [CODE_W-1:0] win_o,
  output logic              any_o
);

  logic [CODE_W-1:0] idx;

  // Walk from lowest to highest priority so the highest-priority hit is written last.
  always_comb begin
    win_o = '0;
    idx   = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      idx = ptr_i + k[CODE_W-1:0];
      if (req_i[idx]) win_o = idx;
    end
  end

  assign any_o = |req_i;

endmodule

// File: rtl/rr_arb4_dec.sv
// Round-robin arbiter driving a 2-to-4 decoder with a one-cycle break-before-make gap.
// Optional forced release after HOLD_MAX grant cycles: define RR_ARB_HOLD_LIMIT_EN.
module rr_arb4_dec
  import rr_arb4_pkg::*;
#(
  parameter int HOLD_MAX = 8,
  parameter int CNT_W    = 4
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic [3:0]       REQ,
  output logic [3:0]       GNT,
  output logic             A0,
  output logic             A1,
  output logic             EN,
  output logic             BUSY,
  output logic [CNT_W-1:0] HOLD_CNT
);

`ifdef RR_ARB_HOLD_LIMIT_EN
  localparam bit LIMIT_EN = 1'b1;
`else
  localparam bit LIMIT_EN = 1'b0;
`endif
  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_MAX - 1);

  state_t            state_q;
  logic [CODE_W-1:0] ptr_q;
  logic [CODE_W-1:0] code_q;
  logic [NREQ-1:0]   gnt_q;
  logic              en_q;
  logic [CNT_W-1:0]  cnt_q;
  logic [CNT_W-1:0]  cnt_d;

  logic [CODE_W-1:0] pick_win;
  logic              pick_any;
  logic              release_w;

  rr_pick4 u_pick (
    .req_i (REQ),
    .ptr_i (ptr_q),
    .win_o (pick_win),
    .any_o (pick_any)
  );

  assign cnt_d     = (cnt_q == '1) ? cnt_q : cnt_q + 1'b1;
  assign release_w = !REQ[code_q] || (LIMIT_EN && (cnt_q == HOLD_LAST));

  // code_q is only rewritten on a new grant, so A1/A0 stay still while EN is low.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= ST_IDLE;
      ptr_q   <= '0;
      code_q  <= '0;
      gnt_q   <= '0;
      en_q    <= 1'b0;
      cnt_q   <= '0;
    end else begin
      case (state_q)
        ST_IDLE, ST_GAP: begin
          cnt_q <= '0;
          if (pick_any) begin
            state_q <= ST_GRANT;
            code_q  <= pick_win;
            gnt_q   <= dec_code(pick_win);
            en_q    <= 1'b1;
          end else begin
            state_q <= ST_IDLE;
            gnt_q   <= '0;
            en_q    <= 1'b0;
          end
        end
        ST_GRANT: begin
          if (release_w) begin
            state_q <= ST_GAP;
            ptr_q   <= code_q + 2'd1;
            gnt_q   <= '0;
            en_q    <= 1'b0;
            cnt_q   <= '0;
          end else begin
            cnt_q <= cnt_d;
          end
        end
        default: begin
          state_q <= ST_IDLE;
          gnt_q   <= '0;
          en_q    <= 1'b0;
          cnt_q   <= '0;
        end
      endcase
    end
  end

  assign GNT      = gnt_q;
  assign A0       = code_q[0];
  assign A1       = code_q[1];
  assign EN       = en_q;
  assign BUSY     = (state_q != ST_IDLE);
  assign HOLD_CNT = cnt_q;

endmodule
